// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: two OBI masters (instr, data) sharing one in-order memory port.
// Optional build macro OBI_ARB_ROUND_ROBIN_EN alternates grants under contention.
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        SEL_INSTR = 1'b0,
        SEL_DATA  = 1'b1
    } sel_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    lock_e                lock_q;
    sel_e                 lock_sel_q;
    sel_e                 sel;
    sel_e                 head;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        cnt_q;
    logic                 full;
    logic                 req_int;
    logic                 push;
    logic                 pop;

`ifdef OBI_ARB_ROUND_ROBIN_EN
    sel_e                 last_q;
`endif

    assign full = (cnt_q == CW'(MAX_OUTSTANDING));
    assign head = sel_e'(fifo_q[rd_ptr_q]);

    // Pick the master: a pending locked request wins, then contention policy.
    always_comb begin
        sel = SEL_INSTR;
        if (lock_q == LOCKED) begin
            sel = lock_sel_q;
        end else if (instr_req_i && data_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            sel = (last_q == SEL_DATA) ? SEL_INSTR : SEL_DATA;
`else
            sel = SEL_DATA;
`endif
        end else if (data_req_i) begin
            sel = SEL_DATA;
        end
    end

    assign req_int = !full &&
                     ((sel == SEL_DATA) ? data_req_i : instr_req_i);
    assign push    = req_int && mem_gnt_i;
    assign pop     = mem_rvalid_i && (cnt_q != '0);

    // Memory-side request mux; everything held at zero while in reset.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (rst_ni) begin
            mem_req_o = req_int;
            if (sel == SEL_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_be_o    = {BW{1'b1}};
            end
        end
    end

    assign instr_gnt_o    = rst_ni && push && (sel == SEL_INSTR);
    assign data_gnt_o     = rst_ni && push && (sel == SEL_DATA);
    assign instr_rvalid_o = rst_ni && pop && (head == SEL_INSTR);
    assign data_rvalid_o  = rst_ni && pop && (head == SEL_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    // Lock FSM: freeze the selection between an ungranted request and its grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= UNLOCKED;
            lock_sel_q <= SEL_INSTR;
        end else begin
            unique case (lock_q)
                UNLOCKED: begin
                    if (req_int && !mem_gnt_i) begin
                        lock_q     <= LOCKED;
                        lock_sel_q <= sel;
                    end
                end
                LOCKED: begin
                    if (req_int && mem_gnt_i) begin
                        lock_q <= UNLOCKED;
                    end
                end
                default: lock_q <= UNLOCKED;
            endcase
        end
    end

    // Routing FIFO: remembers which master owns each outstanding response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // Remember the most recently granted master for alternation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= SEL_INSTR;
        end else if (push) begin
            last_q <= sel;
        end
    end
`endif

endmodule
